// File: rtl/ts_pkt_pack_if.sv
// ts_pkt_pack_if
// Bundles the byte stream from the TS sync stage and the word write bus
// towards the DDR3 write FIFO.
//   ts_in[7:0]     TS byte
//   ts_in_valid    byte strobe (may gap)
//   ts_in_sync     with valid: byte 0 of a packet
//   ts_in_last     with valid: byte 187 of a packet
//   wr_space_ok    FIFO has room for a whole packet (47 words)
//   wr_data[31:0]  packed word, first byte in [31:24]
//   wr_en          word write strobe
//   wr_sop/wr_eop  first/last word of a packet (with wr_en)
//   wr_err         truncated packet marker (with wr_en and wr_eop)
// Modports: slave = packer side, master = stream source / FIFO side.
interface ts_pkt_pack_if;
  logic [7:0]  ts_in;
  logic        ts_in_valid;
  logic        ts_in_sync;
  logic        ts_in_last;
  logic        wr_space_ok;
  logic [31:0] wr_data;
  logic        wr_en;
  logic        wr_sop;
  logic        wr_eop;
  logic        wr_err;

  modport master (
    output ts_in, ts_in_valid, ts_in_sync, ts_in_last, wr_space_ok,
    input  wr_data, wr_en, wr_sop, wr_eop, wr_err
  );

  modport slave (
    input  ts_in, ts_in_valid, ts_in_sync, ts_in_last, wr_space_ok,
    output wr_data, wr_en, wr_sop, wr_eop, wr_err
  );
endinterface

// File: rtl/ts_pkt_pack.sv
// ts_pkt_pack
// Packs byte-aligned 188-byte TS packets into 47 big-endian 32-bit words
// for the DDR3 write FIFO. Null packets and packets arriving while the FIFO
// lacks room are dropped; truncated packets are closed with a flush word
// flagged wr_err. Good/dropped/truncated packets are counted.
// Ports:
//   clk        clock
//   rst        synchronous active-high reset
//   bus        ts_pkt_pack_if.slave (byte stream in, word writes out)
//   cfg_pid_en, cfg_pid[12:0]  PID filter enable/value (PID_FILTER_EN only)
//   pkt_cnt    good packets written
//   drop_cnt   packets dropped (null, filter, no space)
//   err_cnt    truncated packets
// Build option: define PID_FILTER_EN to add the PID filter ports.
module ts_pkt_pack #(
  parameter logic [12:0]  NULL_PID  = 13'h1FFF,
  parameter bit           DROP_NULL = 1'b1,
  parameter int unsigned  CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  ts_pkt_pack_if.slave     bus,
`ifdef PID_FILTER_EN
  input  logic             cfg_pid_en,
  input  logic [12:0]      cfg_pid,
`endif
  output logic [CNT_W-1:0] pkt_cnt,
  output logic [CNT_W-1:0] drop_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PACK = 2'd1,
    DROP = 2'd2
  } state_t;

  localparam logic [7:0]       LAST_IDX = 8'd187;
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t      state, state_nxt;
  // Index of the most recently accepted byte of the current packet.
  logic [7:0]  byte_cnt, cnt_nxt;
  logic [7:0]  idx_in;
  // Last three bytes received; the fourth is taken straight from ts_in.
  logic [23:0] sr, sr_nxt;
  logic [31:0] word;
  logic [12:0] pid;
  logic        pid_drop;
  logic        start;

  logic [31:0] data_r, data_nxt;
  logic        en_r, en_nxt;
  logic        sop_r, sop_nxt;
  logic        eop_r, eop_nxt;
  logic        err_r, err_nxt;
  logic        pkt_inc, drop_inc, err_inc;

  assign bus.wr_data = data_r;
  assign bus.wr_en   = en_r;
  assign bus.wr_sop  = sop_r;
  assign bus.wr_eop  = eop_r;
  assign bus.wr_err  = err_r;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      byte_cnt <= '0;
      sr       <= '0;
      data_r   <= '0;
      en_r     <= 1'b0;
      sop_r    <= 1'b0;
      eop_r    <= 1'b0;
      err_r    <= 1'b0;
      pkt_cnt  <= '0;
      drop_cnt <= '0;
      err_cnt  <= '0;
    end else begin
      state    <= state_nxt;
      byte_cnt <= cnt_nxt;
      sr       <= sr_nxt;
      data_r   <= data_nxt;
      en_r     <= en_nxt;
      sop_r    <= sop_nxt;
      eop_r    <= eop_nxt;
      err_r    <= err_nxt;
      if (pkt_inc)  pkt_cnt  <= pkt_cnt  + CNT_ONE;
      if (drop_inc) drop_cnt <= drop_cnt + CNT_ONE;
      if (err_inc)  err_cnt  <= err_cnt  + CNT_ONE;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = byte_cnt;
    sr_nxt    = sr;
    data_nxt  = '0;
    en_nxt    = 1'b0;
    sop_nxt   = 1'b0;
    eop_nxt   = 1'b0;
    err_nxt   = 1'b0;
    pkt_inc   = 1'b0;
    drop_inc  = 1'b0;
    err_inc   = 1'b0;
    start     = 1'b0;

    idx_in = byte_cnt + 8'd1;
    word   = {sr, bus.ts_in};
    // At byte 3, sr[15:8] holds byte 1 and sr[7:0] holds byte 2.
    pid      = sr[12:0];
    pid_drop = DROP_NULL && (pid == NULL_PID);
`ifdef PID_FILTER_EN
    if (cfg_pid_en && (pid != cfg_pid)) pid_drop = 1'b1;
`endif

    if (bus.ts_in_valid) begin
      case (state)
        // A sync with last in IDLE still opens a packet; there is nothing to truncate yet.
        IDLE: start = bus.ts_in_sync;

        PACK: begin
          if (bus.ts_in_sync) begin
            // Early sync: flush only the bytes gathered since the last full
            // word; the sync byte itself opens the next packet. A flush that
            // is the packet's only write also carries wr_sop.
            en_nxt  = 1'b1;
            eop_nxt = 1'b1;
            err_nxt = 1'b1;
            err_inc = 1'b1;
            sop_nxt = (byte_cnt < 8'd3);
            case (byte_cnt[1:0])
              2'd0:    data_nxt = {sr[7:0],  24'h0};
              2'd1:    data_nxt = {sr[15:0], 16'h0};
              2'd2:    data_nxt = {sr[23:0], 8'h0};
              default: data_nxt = '0;
            endcase
            start = 1'b1;
          end else if (bus.ts_in_last != (idx_in == LAST_IDX)) begin
            // Early last, or byte 187 without last: the trigger byte still
            // belongs to this packet, so it is included in the flush word.
            en_nxt  = 1'b1;
            eop_nxt = 1'b1;
            err_nxt = 1'b1;
            err_inc = 1'b1;
            sop_nxt = (idx_in <= 8'd3);
            case (idx_in[1:0])
              2'd0:    data_nxt = {bus.ts_in, 24'h0};
              2'd1:    data_nxt = {sr[7:0],  bus.ts_in, 16'h0};
              2'd2:    data_nxt = {sr[15:0], bus.ts_in, 8'h0};
              default: data_nxt = word;
            endcase
            state_nxt = IDLE;
            cnt_nxt   = '0;
          end else begin
            sr_nxt  = word[23:0];
            cnt_nxt = idx_in;
            if (idx_in[1:0] == 2'd3) begin
              if ((idx_in == 8'd3) && pid_drop) begin
                state_nxt = DROP;
                drop_inc  = 1'b1;
              end else begin
                en_nxt   = 1'b1;
                data_nxt = word;
                sop_nxt  = (idx_in == 8'd3);
                if (idx_in == LAST_IDX) begin
                  eop_nxt   = 1'b1;
                  pkt_inc   = 1'b1;
                  state_nxt = IDLE;
                  cnt_nxt   = '0;
                end
              end
            end
          end
        end

        DROP: begin
          if (bus.ts_in_sync) begin
            start = 1'b1;
          end else if (bus.ts_in_last || (idx_in == LAST_IDX)) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = idx_in;
          end
        end

        default: state_nxt = IDLE;
      endcase

      if (start) begin
        cnt_nxt = '0;
        sr_nxt  = {16'h0, bus.ts_in};
        if (bus.wr_space_ok) begin
          state_nxt = PACK;
        end else begin
          state_nxt = DROP;
          drop_inc  = 1'b1;
        end
      end
    end
  end

endmodule
